// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN vote accumulator: parameter defaults and FSM states.
package bnn_pkg;

    localparam int NUM_CLASSES_DEF = 4;
    localparam int CNT_W_DEF       = 8;
    // Width of the winner index presented on out_winner.
    localparam int WIN_W           = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RESOLVE,
        ST_OUTPUT
    } state_t;

endpackage

// File: rtl/bnn_class_counter.sv
// Per-class vote counter: synchronous clear takes priority over increment.
module bnn_class_counter
    import bnn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count votes for this class; window length bounds the value so no saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Accumulates multi-hot class votes over a window, then scans the counters
// one class per cycle to find the winner, tie and all-zero conditions.
module bnn_vote_accumulator
    import bnn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear,
    input  logic [CNT_W-1:0]       win_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] in_class,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIN_W-1:0]       out_winner,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_tie,
    output logic                   out_none,
    output logic                   busy
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_win_len;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [WIN_W-1:0]   r_scan_idx;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [WIN_W-1:0]   r_best_idx;
    logic               r_tie;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic [WIN_W-1:0]   r_out_winner;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_tie;
    logic               r_out_none;

    logic               w_accept;
    logic               w_start_ok;
    logic               w_cnt_clr;
    logic [NUM_CLASSES-1:0] w_inc;
    logic [CNT_W-1:0]   w_cnt [NUM_CLASSES];
    logic [CNT_W-1:0]   w_sample_next;
    logic [CNT_W-1:0]   w_cur;
    logic [CNT_W-1:0]   w_nbest_cnt;
    logic [WIN_W-1:0]   w_nbest_idx;
    logic               w_ntie;
    logic               w_scan_last;

    assign w_accept      = in_valid & r_in_ready;
    assign w_start_ok    = start & (r_state == ST_IDLE);
    assign w_cnt_clr     = clear | w_start_ok;
    assign w_sample_next = r_sample_cnt + 1'b1;
    assign w_scan_last   = (r_scan_idx == WIN_W'(NUM_CLASSES - 1));

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cls
        // clear outranks a sample accepted in the same cycle
        assign w_inc[g] = w_accept & in_class[g] & ~clear;

        bnn_class_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (w_cnt_clr),
            .i_inc   (w_inc[g]),
            .o_count (w_cnt[g])
        );
    end

    // One scan step: first class loads the best, later classes replace only when strictly greater.
    always_comb begin
        w_cur       = w_cnt[r_scan_idx];
        w_nbest_cnt = r_best_cnt;
        w_nbest_idx = r_best_idx;
        w_ntie      = r_tie;
        if (r_scan_idx == '0) begin
            w_nbest_cnt = w_cur;
            w_nbest_idx = '0;
            w_ntie      = 1'b0;
        end else if (w_cur > r_best_cnt) begin
            w_nbest_cnt = w_cur;
            w_nbest_idx = r_scan_idx;
            w_ntie      = 1'b0;
        end else if (w_cur == r_best_cnt) begin
            w_ntie      = 1'b1;
        end
    end

    // Window control FSM with registered handshake, busy and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_win_len    <= '0;
            r_sample_cnt <= '0;
            r_scan_idx   <= '0;
            r_best_cnt   <= '0;
            r_best_idx   <= '0;
            r_tie        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_winner <= '0;
            r_out_count  <= '0;
            r_out_tie    <= 1'b0;
            r_out_none   <= 1'b0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_scan_idx   <= '0;
            r_best_cnt   <= '0;
            r_best_idx   <= '0;
            r_tie        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_winner <= '0;
            r_out_count  <= '0;
            r_out_tie    <= 1'b0;
            r_out_none   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_win_len    <= win_len;
                        r_sample_cnt <= '0;
                        r_scan_idx   <= '0;
                        r_busy       <= 1'b1;
                        if (win_len != '0) begin
                            r_state    <= ST_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_RESOLVE;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_sample_cnt <= w_sample_next;
                        if (w_sample_next == r_win_len) begin
                            r_state    <= ST_RESOLVE;
                            r_in_ready <= 1'b0;
                            r_scan_idx <= '0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_best_cnt <= w_nbest_cnt;
                    r_best_idx <= w_nbest_idx;
                    r_tie      <= w_ntie;
                    if (w_scan_last) begin
                        r_state     <= ST_OUTPUT;
                        r_out_valid <= 1'b1;
                        if (w_nbest_cnt == '0) begin
                            r_out_none   <= 1'b1;
                            r_out_winner <= '0;
                            r_out_count  <= '0;
                            r_out_tie    <= 1'b0;
                        end else begin
                            r_out_none   <= 1'b0;
                            r_out_winner <= w_nbest_idx;
                            r_out_count  <= w_nbest_cnt;
                            r_out_tie    <= w_ntie;
                        end
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_winner = r_out_winner;
    assign out_count  = r_out_count;
    assign out_tie    = r_out_tie;
    assign out_none   = r_out_none;

endmodule

// File: doc/bnn_vote_accumulator.md
BNN_VOTE_ACCUMULATOR -- requirements
Module: bnn_vote_accumulator

Interface
REQ-001 Parameter NUM_CLASSES, default 4, number of class lines from final BNN layer.
REQ-002 Parameter CNT_W, default 8, width of per-class counters and window length.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a voting window; honoured only in IDLE.
REQ-006 clear  input  1  synchronous abort; returns to IDLE, zeroes all counters.
REQ-007 win_len  input  CNT_W  samples per window, sampled on accepted start.
REQ-008 in_valid  input  1  in_class carries a valid final-layer result.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 in_class  input  NUM_CLASSES  final-layer neuron outputs (multi-hot permitted).
REQ-011 out_valid  output  1  result registers valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_winner  output  2  index of class with highest count.
REQ-014 out_count  output  CNT_W  count of winning class.
REQ-015 out_tie  output  1  another class equals the winning count.
REQ-016 out_none  output  1  all class counts zero.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states IDLE, ACCUM, RESOLVE, OUTPUT; reset state IDLE.
REQ-019 IDLE->ACCUM on start with win_len!=0: latch win_len, zero counters and sample counter.
REQ-020 IDLE->RESOLVE on start with win_len==0: counters zero, window empty.
REQ-021 in_ready = 1 exactly in ACCUM; sample accepted when in_valid && in_ready.
REQ-022 Per accepted sample: each class counter with in_class[c]=1 increments by 1; sample counter increments by 1.
REQ-023 Counters never overflow (max value = win_len <= 2^CNT_W-1); no saturation logic required.
REQ-024 ACCUM->RESOLVE on the cycle the sample counter reaches the latched win_len (the win_len-th accept).
REQ-025 RESOLVE scans classes 0..NUM_CLASSES-1, one class per cycle; exactly NUM_CLASSES cycles.
REQ-026 Scan rule: strictly greater count replaces best and clears tie; equal count sets tie; lowest index wins ties.
REQ-027 RESOLVE->OUTPUT after last compare; out_valid rises first OUTPUT cycle (NUM_CLASSES+1 cycles after last accept).
REQ-028 out_none=1 when best count is 0; then out_winner=0, out_tie=0, out_count=0.
REQ-029 out_valid and all result outputs held stable in OUTPUT until out_valid && out_ready.
REQ-030 On output accept: OUTPUT->IDLE; start same cycle is ignored (needs IDLE next cycle).
REQ-031 start outside IDLE ignored; win_len changes outside IDLE have no effect.
REQ-032 clear in any state: next state IDLE, counters zero, out_valid 0; clear has priority over start, sample accept, output accept.
REQ-033 in_valid while not ACCUM: sample dropped, no counter change.

Reset
REQ-034 reset asserted: state IDLE, all counters 0, in_ready 0, out_valid 0, out_winner 0, out_count 0, out_tie 0, out_none 0, busy 0.
REQ-035 reset mid-window discards partial window; no result produced.

Structure
REQ-036 Shared package bnn_pkg holds NUM_CLASSES, CNT_W defaults and the FSM state enum.
REQ-037 One sub-module bnn_class_counter (per-class counter with clear/inc), instantiated NUM_CLASSES times; scan/FSM in top.

Verification
REQ-038 win_len=3, samples 0001,0001,0010 -> out_winner=0, out_count=2, out_tie=0, out_valid 5 cycles after 3rd accept.
REQ-039 win_len=2, samples 0110,0110 -> out_winner=1, out_count=2, out_tie=1.
REQ-040 win_len=4, four samples 0000 -> out_none=1, out_winner=0, out_count=0.
REQ-041 win_len=0 start -> out_valid after 4 RESOLVE cycles, out_none=1, no in_ready pulse.
REQ-042 out_ready low 10 cycles -> outputs stable; start during OUTPUT ignored; accept -> busy 0 next cycle.
REQ-043 clear after 2 of 5 samples, then fresh window win_len=1 sample 1000 -> out_winner=3, out_count=1 (no residue).
